// File: rtl/force_ctrl.sv
// force_ctrl -- per-bit override controller for a functional signal.
//
// Overrides selected bits of func_in with a stored value, either indefinitely
// (FORCE) or for a programmed number of cycles (FORCE_TIMED). Bits can be
// handed back to the functional source with RELEASE. Commands take effect in
// sig_out on the cycle after they are accepted.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst         : synchronous active-high reset
//   func_in     : functional value of the controlled signal
//   cmd_valid   : command present this cycle
//   cmd_ready   : command accepted when cmd_valid && cmd_ready (low in reset)
//   cmd_op      : 00 NOP, 01 FORCE, 10 RELEASE, 11 FORCE_TIMED
//   cmd_value   : override value for FORCE / FORCE_TIMED
//   cmd_mask    : bits affected by the command (1 = affected)
//   cmd_cycles  : hold duration for FORCE_TIMED (0 behaves as 1)
//   sig_out     : effective signal, forced value on forced bits else func_in
//   force_mask  : currently forced bits
//   forced      : high when any bit is forced
//   done        : one-cycle pulse when a timed force expires
module force_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] func_in,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_value,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CW-1:0]    cmd_cycles,
  output logic [WIDTH-1:0] sig_out,
  output logic [WIDTH-1:0] force_mask,
  output logic             forced,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HELD  = 2'd1,
    S_TIMED = 2'd2
  } state_e;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_FORCE = 2'b01;
  localparam logic [1:0] OP_REL   = 2'b10;
  localparam logic [1:0] OP_FT    = 2'b11;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] fval_q, fval_d;
  logic [CW-1:0]    timer_q, timer_d;
  logic             done_q, done_d;

  logic             cmd_eff;
  logic             expire;
  logic [WIDTH-1:0] rel_mask;
  logic [WIDTH-1:0] frc_mask;
  logic [WIDTH-1:0] frc_fval;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      fval_q  <= '0;
      timer_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      fval_q  <= fval_d;
      timer_q <= timer_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    fval_d   = fval_q;
    timer_d  = timer_q;
    done_d   = 1'b0;

    // A command with an empty mask (or a NOP) is a no-op and must not
    // disturb a running timer, so only "effective" commands interact with it.
    cmd_eff  = cmd_valid && !rst && (cmd_op != OP_NOP) && (cmd_mask != '0);
    expire   = (state_q == S_TIMED) && (timer_q == CW'(1));
    rel_mask = mask_q & ~cmd_mask;
    frc_mask = mask_q | cmd_mask;
    frc_fval = (fval_q & ~cmd_mask) | (cmd_value & cmd_mask);

    if (cmd_eff) begin
      case (cmd_op)
        OP_FORCE: begin
          // Forcing cancels any timer: every forced bit becomes held.
          mask_d  = frc_mask;
          fval_d  = frc_fval;
          timer_d = '0;
          state_d = S_HELD;
        end
        OP_FT: begin
          mask_d  = frc_mask;
          fval_d  = frc_fval;
          timer_d = (cmd_cycles == '0) ? CW'(1) : cmd_cycles;
          state_d = S_TIMED;
        end
        default: begin
          if (expire) begin
            // Release racing the expiry: expiry still completes and reports.
            mask_d  = '0;
            timer_d = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            mask_d = rel_mask;
            if (rel_mask == '0) begin
              timer_d = '0;
              state_d = S_IDLE;
            end else if (state_q == S_TIMED) begin
              timer_d = timer_q - CW'(1);
            end else begin
              state_d = S_HELD;
            end
          end
        end
      endcase
    end else if (state_q == S_TIMED) begin
      if (expire) begin
        mask_d  = '0;
        timer_d = '0;
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        timer_d = timer_q - CW'(1);
      end
    end
  end

  // Output logic
  always_comb begin
    cmd_ready  = !rst;
    force_mask = mask_q;
    forced     = |mask_q;
    done       = done_q;
    sig_out    = (func_in & ~mask_q) | (fval_q & mask_q);
  end

endmodule

// File: tb/tb_force_ctrl.sv
module tb_force_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] func_in;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_value;
  logic [3:0] cmd_mask;
  logic [7:0] cmd_cycles;
  logic [3:0] sig_out;
  logic [3:0] force_mask;
  logic       forced;
  logic       done;

  int total;
  int bad;

  force_ctrl #(.WIDTH(4), .CW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .func_in    (func_in),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_value  (cmd_value),
    .cmd_mask   (cmd_mask),
    .cmd_cycles (cmd_cycles),
    .sig_out    (sig_out),
    .force_mask (force_mask),
    .forced     (forced),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; outputs are examined 2 time units after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present one command for a single edge, then drop valid.
  task automatic send(input logic [1:0] op, input logic [3:0] val,
                      input logic [3:0] msk, input logic [7:0] cyc);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_value  = val;
    cmd_mask   = msk;
    cmd_cycles = cyc;
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    send(2'b01, 4'b1010, 4'b1111, 8'd0);
    step();
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%b want=0", cmd_ready);
    end
    total++;
    if (sig_out !== 4'b0101 || forced !== 1'b0 || force_mask !== 4'b0000) begin
      bad++; $display("FAIL reset_state got sig=%b fm=%b forced=%b want sig=0101 fm=0000 forced=0",
                      sig_out, force_mask, forced);
    end
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL reset_done got=%b want=0", done);
    end
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_reset got=%b want=1", cmd_ready);
    end
  endtask

  task automatic test_force_release();
    send(2'b01, 4'b1010, 4'b1111, 8'd0);
    total++;
    if (sig_out !== 4'b1010 || forced !== 1'b1) begin
      bad++; $display("FAIL force_all got sig=%b forced=%b want sig=1010 forced=1", sig_out, forced);
    end
    send(2'b10, 4'b0000, 4'b1111, 8'd0);
    total++;
    if (sig_out !== 4'b0101 || forced !== 1'b0) begin
      bad++; $display("FAIL release_all got sig=%b forced=%b want sig=0101 forced=0", sig_out, forced);
    end
  endtask

  task automatic test_partial();
    send(2'b01, 4'b1100, 4'b0011, 8'd0);
    total++;
    if (sig_out !== 4'b0100 || force_mask !== 4'b0011) begin
      bad++; $display("FAIL partial_force got sig=%b fm=%b want sig=0100 fm=0011", sig_out, force_mask);
    end
    func_in = 4'b1001;
    #1;
    total++;
    if (sig_out !== 4'b1000) begin
      bad++; $display("FAIL partial_track got=%b want=1000", sig_out);
    end
    send(2'b10, 4'b0000, 4'b0001, 8'd0);
    total++;
    if (sig_out !== 4'b1001 || force_mask !== 4'b0010 || forced !== 1'b1) begin
      bad++; $display("FAIL partial_release got sig=%b fm=%b forced=%b want sig=1001 fm=0010 forced=1",
                      sig_out, force_mask, forced);
    end
    send(2'b10, 4'b0000, 4'b0010, 8'd0);
    total++;
    if (force_mask !== 4'b0000 || forced !== 1'b0) begin
      bad++; $display("FAIL partial_release_rest got fm=%b forced=%b want fm=0000 forced=0", force_mask, forced);
    end
    func_in = 4'b0101;
    #1;
  endtask

  task automatic test_mask_zero();
    send(2'b01, 4'b1111, 4'b0000, 8'd0);
    total++;
    if (sig_out !== 4'b0101 || forced !== 1'b0) begin
      bad++; $display("FAIL mask_zero got sig=%b forced=%b want sig=0101 forced=0", sig_out, forced);
    end
  endtask

  task automatic test_timed();
    send(2'b11, 4'b1111, 4'b1111, 8'd3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (sig_out !== 4'b1111 || done !== 1'b0) begin
        bad++; $display("FAIL timed3_hold[%0d] got sig=%b done=%b want sig=1111 done=0", i, sig_out, done);
      end
      step();
    end
    total++;
    if (sig_out !== 4'b0101 || done !== 1'b1 || forced !== 1'b0) begin
      bad++; $display("FAIL timed3_expire got sig=%b done=%b forced=%b want sig=0101 done=1 forced=0",
                      sig_out, done, forced);
    end
    step();
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL timed3_done_pulse got=%b want=0", done);
    end
    send(2'b11, 4'b1111, 4'b1111, 8'd0);
    total++;
    if (sig_out !== 4'b1111) begin
      bad++; $display("FAIL timed0_hold got=%b want=1111", sig_out);
    end
    step();
    total++;
    if (sig_out !== 4'b0101 || done !== 1'b1) begin
      bad++; $display("FAIL timed0_expire got sig=%b done=%b want sig=0101 done=1", sig_out, done);
    end
    step();
  endtask

  task automatic test_reload();
    send(2'b11, 4'b1111, 4'b1111, 8'd5);
    step();
    send(2'b11, 4'b1111, 4'b1111, 8'd2);
    total++;
    if (sig_out !== 4'b1111 || done !== 1'b0) begin
      bad++; $display("FAIL reload_c1 got sig=%b done=%b want sig=1111 done=0", sig_out, done);
    end
    step();
    total++;
    if (sig_out !== 4'b1111 || done !== 1'b0) begin
      bad++; $display("FAIL reload_c2 got sig=%b done=%b want sig=1111 done=0", sig_out, done);
    end
    step();
    total++;
    if (sig_out !== 4'b0101 || done !== 1'b1) begin
      bad++; $display("FAIL reload_expire got sig=%b done=%b want sig=0101 done=1", sig_out, done);
    end
    step();
    send(2'b11, 4'b1111, 4'b1111, 8'd2);
    send(2'b01, 4'b1010, 4'b1111, 8'd0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sig_out !== 4'b1010 || done !== 1'b0 || forced !== 1'b1) begin
        bad++; $display("FAIL timed_to_held[%0d] got sig=%b done=%b forced=%b want sig=1010 done=0 forced=1",
                        i, sig_out, done, forced);
      end
      step();
    end
    send(2'b10, 4'b0000, 4'b1111, 8'd0);
  endtask

  task automatic test_reset_mid();
    send(2'b11, 4'b1111, 4'b1111, 8'd4);
    step();
    rst = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_ready got=%b want=0", cmd_ready);
    end
    step();
    total++;
    if (sig_out !== 4'b0101 || forced !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL midrst_abort got sig=%b forced=%b done=%b want sig=0101 forced=0 done=0",
                      sig_out, forced, done);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (done !== 1'b0 || sig_out !== 4'b0101) begin
        bad++; $display("FAIL midrst_nodone[%0d] got done=%b sig=%b want done=0 sig=0101", i, done, sig_out);
      end
    end
  endtask

  task automatic test_expiry_collide();
    send(2'b11, 4'b1111, 4'b1111, 8'd2);
    step();
    send(2'b01, 4'b0011, 4'b1111, 8'd0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (sig_out !== 4'b0011 || done !== 1'b0 || forced !== 1'b1) begin
        bad++; $display("FAIL collide_force[%0d] got sig=%b done=%b forced=%b want sig=0011 done=0 forced=1",
                        i, sig_out, done, forced);
      end
      step();
    end
    send(2'b10, 4'b0000, 4'b1111, 8'd0);
    send(2'b11, 4'b1111, 4'b1111, 8'd2);
    step();
    send(2'b10, 4'b0000, 4'b0001, 8'd0);
    total++;
    if (sig_out !== 4'b0101 || done !== 1'b1 || force_mask !== 4'b0000) begin
      bad++; $display("FAIL collide_release got sig=%b done=%b fm=%b want sig=0101 done=1 fm=0000",
                      sig_out, done, force_mask);
    end
    step();
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL collide_release_pulse got=%b want=0", done);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    func_in    = 4'b0101;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_value  = 4'b0000;
    cmd_mask   = 4'b0000;
    cmd_cycles = 8'd0;
    #1;
    test_reset();
    test_force_release();
    test_partial();
    test_mask_zero();
    test_timed();
    test_reload();
    test_reset_mid();
    test_expiry_collide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/force_ctrl.md
FORCE_CTRL -- requirements
Module: force_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: width of the controlled signal.
REQ-002 Parameter CW, default 8: width of the timed-force cycle count.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 func_in  input  WIDTH  continuously driven functional value of the signal.
REQ-006 cmd_valid  input  1  command present this cycle.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_op  input  2  command: 00 NOP, 01 FORCE, 10 RELEASE, 11 FORCE_TIMED.
REQ-009 cmd_value  input  WIDTH  override value for FORCE and FORCE_TIMED.
REQ-010 cmd_mask  input  WIDTH  bits affected by the command; 1 = affected.
REQ-011 cmd_cycles  input  CW  hold duration for FORCE_TIMED.
REQ-012 sig_out  output  WIDTH  effective signal value: per bit, forced value or func_in.
REQ-013 force_mask  output  WIDTH  currently forced bits.
REQ-014 forced  output  1  high when force_mask != 0.
REQ-015 done  output  1  one-cycle pulse when a timed force expires.

Function
REQ-016 sig_out SHALL be (func_in & ~force_mask) | (fval & force_mask), combinational from the registered fval/force_mask; unforced bits track func_in with zero latency.
REQ-017 cmd_ready SHALL be high in every state and low while rst is high.
REQ-018 Accepted commands SHALL take effect in sig_out starting the cycle after acceptance.
REQ-019 FORCE SHALL set force_mask |= cmd_mask and load fval with cmd_value on the masked bits; other fval bits remain unchanged.
REQ-020 RELEASE SHALL clear force_mask &= ~cmd_mask; released bits return to func_in the next cycle; fval is not cleared.
REQ-021 NOP, and any command with cmd_mask == 0, SHALL change no state.
REQ-022 States: IDLE (force_mask == 0), HELD (force_mask != 0, no timer), TIMED (timer running).
REQ-023 IDLE/HELD --FORCE--> HELD; any state --FORCE_TIMED--> TIMED; TIMED --FORCE--> HELD (timer cancelled, all forced bits become permanently held).
REQ-024 FORCE_TIMED SHALL apply the FORCE update and load the timer with cmd_cycles; cmd_cycles == 0 SHALL be treated as 1.
REQ-025 FORCE_TIMED in TIMED SHALL reload the timer; the old duration is discarded.
REQ-026 In TIMED, the timer SHALL decrement each cycle; sig_out SHALL show the forced value for exactly N cycles after acceptance.
REQ-027 Expiry (timer == 1 with no accepted command): the next cycle SHALL have force_mask = 0, state IDLE, done = 1 for exactly that cycle.
REQ-028 RELEASE in TIMED leaving force_mask != 0 SHALL stay in TIMED with the timer running; leaving force_mask == 0 SHALL go to IDLE, cancel the timer, and not pulse done.
REQ-029 RELEASE in HELD that clears all bits SHALL go to IDLE.
REQ-030 Expiry coinciding with an accepted FORCE or FORCE_TIMED: the command wins and expiry is suppressed (no done).
REQ-031 Expiry coinciding with an accepted RELEASE: all bits are cleared, state goes to IDLE, and done pulses.
REQ-032 forced SHALL equal |force_mask at all times.

Reset
REQ-033 Under rst: force_mask = 0, fval = 0, timer = 0, state = IDLE, done = 0, forced = 0, cmd_ready = 0; sig_out = func_in.
REQ-034 Reset asserted mid-TIMED SHALL abort the force without a done pulse; commands presented during rst are ignored.

Verification (WIDTH=4, func_in=4'b0101 unless stated)
REQ-035 FORCE value 1010 mask 1111 -> next cycle sig_out=1010, forced=1; RELEASE mask 1111 -> next cycle sig_out=0101, forced=0.
REQ-036 FORCE value 1100 mask 0011, then func_in->1001 -> sig_out=1000; RELEASE mask 0001 -> sig_out=1001, force_mask=0010.
REQ-037 FORCE_TIMED value 1111 mask 1111 cycles 3 -> sig_out=1111 for exactly 3 cycles, then 0101 with done=1 for one cycle; cycles 0 -> 1 forced cycle.
REQ-038 FORCE_TIMED cycles 5, FORCE_TIMED cycles 2 on cycle 2 -> forced 2 more cycles then done; FORCE during TIMED -> stays forced indefinitely, no done.
REQ-039 FORCE_TIMED cycles 4, rst high on cycle 2 -> sig_out=0101 next cycle, done never pulses, cmd_ready=0 during rst.
REQ-040 FORCE_TIMED cycles 2 with FORCE on the expiry cycle -> remains HELD, no done; RELEASE on the expiry cycle -> IDLE, done=1.
